thumb_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the `cortex_m0` decode/execute core (ControlUnit + Datapath). Issues word-aligned reads to instruction memory and splits returned words into Thumb halfwords in a small prefetch FIFO. Assembles 16-bit and 32-bit Thumb instructions and presents them to decode with a valid/ready handshake. Flushes and redirects on branch.

---
 rtl/cm0_fetch_pkg.sv | 16 +
 rtl/thumb_fetch_unit_chk.sv | 16 +
 rtl/thumb_fetch_unit_hw_fifo.sv | 55 +++++
 rtl/thumb_fetch_unit.sv | 119 +++++++++++
 tb/tb_thumb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cm0_fetch_pkg.sv
// Shared types, defaults and the Thumb-2 length decoder for the fetch stage.
package cm0_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FETCH_DEPTH      = 4;

  typedef logic [15:0] halfword_t;

  // A halfword opens a 32-bit encoding when its top five bits are 11101, 11110 or 11111.
  function automatic logic is_thumb32(input halfword_t hw);
    halfword_t top;
    top = hw >> 11;
    return (top == 16'd29) || (top == 16'd30) || (top == 16'd31);
  endfunction

endpackage

// File: rtl/thumb_fetch_unit_chk.sv
// Invariant checker for the fetch unit: occupancy bound and word-aligned fetch address.
module thumb_fetch_unit_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic [$clog2(DEPTH):0] count,
  input logic [1:0]             addr_lo
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH));
  a_addr_align:  assert property (@(posedge clk) disable iff (!rst) addr_lo == 2'b00);

endmodule

// File: rtl/thumb_fetch_unit_hw_fifo.sv
// Halfword prefetch FIFO: up to two pushes and two pops per cycle, with flush.
module hw_fifo
  import cm0_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               push_n,
  input  halfword_t                push_hw0,
  input  halfword_t                push_hw1,
  input  logic [1:0]               pop_n,
  output logic [$clog2(DEPTH):0]   count,
  output halfword_t                head0,
  output halfword_t                head1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  halfword_t       mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];

  // Storage, pointers and occupancy; flush only rewinds pointers, contents are stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 16'h0000;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_n != 2'd0) begin
        mem[wr_ptr] <= push_hw0;
      end
      if (push_n == 2'd2) begin
        mem[wr_ptr + AW'(1)] <= push_hw1;
      end
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

endmodule

// File: rtl/thumb_fetch_unit.sv
// Thumb fetch stage: word fetch with one outstanding read, halfword prefetch,
// 16/32-bit instruction assembly and branch redirect.
module thumb_fetch_unit
  import cm0_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        instr_is32,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_addr;
  logic [31:0]   pc_head;
  logic          outstanding;
  logic          drop_resp;
  logic          skip_hw;
  logic [CW-1:0] count;
  halfword_t     head0;
  halfword_t     head1;
  logic          rsp;
  logic          take_data;
  logic          head_is32;
  logic          room_ok;
  logic          req_fire;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;

  // A response only counts while a request is in flight; late data after reset is ignored.
  assign rsp       = imem_rvalid && outstanding;
  assign take_data = rsp && !drop_resp && !branch;
  assign push_n    = take_data ? (skip_hw ? 2'd1 : 2'd2) : 2'd0;

  assign head_is32   = is_thumb32(head0);
  assign instr_valid = !branch && (head_is32 ? (count >= CW'(2)) : (count >= CW'(1)));
  assign pop_n       = (instr_valid && instr_ready) ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
  assign instr_is32  = head_is32;
  assign instr       = head_is32 ? {head0, head1} : {16'h0000, head0};
  assign instr_pc    = pc_head;

  // Space for a full word must remain after this cycle's push and pop, so a request
  // issued alongside a response can never overfill the FIFO.
  assign room_ok  = ({1'b0, count} + (CW+1)'(push_n)) <= ((CW+1)'(DEPTH - 2) + (CW+1)'(pop_n));
  // rst gates the request so the output reads 0 while reset is held.
  assign imem_req  = rst && !branch && (!outstanding || rsp) && room_ok;
  assign req_fire  = imem_req && imem_ready;
  assign imem_addr = fetch_addr;

  hw_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (branch),
    .push_n   (push_n),
    .push_hw0 (skip_hw ? imem_rdata[31:16] : imem_rdata[15:0]),
    .push_hw1 (imem_rdata[31:16]),
    .pop_n    (pop_n),
    .count    (count),
    .head0    (head0),
    .head1    (head1)
  );

  thumb_fetch_unit_chk #(.DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .count   (count),
    .addr_lo (fetch_addr[1:0])
  );

  // Fetch address, head PC and request bookkeeping, with branch redirect taking priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_addr  <= RESET_PC & ~32'h0000_0003;
      pc_head     <= RESET_PC & ~32'h0000_0001;
      outstanding <= 1'b0;
      drop_resp   <= 1'b0;
      skip_hw     <= RESET_PC[1];
    end else begin
      if (req_fire) begin
        outstanding <= 1'b1;
      end else if (rsp) begin
        outstanding <= 1'b0;
      end
      if (branch) begin
        fetch_addr <= branch_target & ~32'h0000_0003;
        pc_head    <= branch_target & ~32'h0000_0001;
        skip_hw    <= branch_target[1];
        drop_resp  <= outstanding && !imem_rvalid;
      end else begin
        if (req_fire) begin
          fetch_addr <= fetch_addr + 32'd4;
        end
        if (pop_n != 2'd0) begin
          pc_head <= pc_head + (head_is32 ? 32'd4 : 32'd2);
        end
        if (rsp) begin
          drop_resp <= 1'b0;
          if (!drop_resp) begin
            skip_hw <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_thumb_fetch_unit.sv
// Self-checking bench: memory responder plus a PC-walking reference of the instruction stream.
module tb_thumb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_is32;
  logic [31:0] instr_pc;
  logic        instr_ready;

  thumb_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch        (branch),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_is32    (instr_is32),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [0:255];
  logic        pend;
  int          pend_wait;
  logic [31:0] pend_addr;
  logic [31:0] exp_pc;
  logic [31:0] exp_req_addr;
  int          lat_min;
  int          lat_max;
  logic        spur_en;
  logic        force_stale;
  int          idle;
  int          delivered;
  logic        last_req;
  logic        last_valid;
  logic        last_is32;
  logic        last_acc;
  logic [31:0] last_addr;
  logic [31:0] last_instr;
  logic [31:0] last_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic opens_32(input logic [15:0] h);
    logic [4:0] t;
    t = h[15:11];
    return (t == 5'b11101) || (t == 5'b11110) || (t == 5'b11111);
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    if (opens_32(hw_at(pc))) return {hw_at(pc), hw_at(pc + 32'd2)};
    return {16'h0000, hw_at(pc)};
  endfunction

  // One clock cycle: drive inputs, let outputs settle, compare against the model, advance.
  task automatic cycle(input logic br, input logic [31:0] tgt, input logic rdy_i, input logic mrdy);
    branch        = br;
    branch_target = tgt;
    instr_ready   = rdy_i;
    imem_ready    = mrdy;
    imem_rdata    = $urandom;
    imem_rvalid   = 1'b0;
    if (pend && pend_wait == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem[pend_addr[9:2]];
    end else if (!pend && (force_stale || (spur_en && $urandom_range(0, 7) == 0))) begin
      imem_rvalid = 1'b1;
    end
    force_stale = 1'b0;
    #2;
    last_req   = imem_req;
    last_addr  = imem_addr;
    last_valid = instr_valid;
    last_instr = instr;
    last_is32  = instr_is32;
    last_pc    = instr_pc;
    last_acc   = imem_req && mrdy;
    check_eq("addr_align", 32'(imem_addr[1:0]), 32'd0);
    if (br) check_eq("valid_in_branch", 32'(instr_valid), 32'd0);
    if (instr_valid) begin
      check_eq("instr_pc", instr_pc, exp_pc);
      check_eq("instr", instr, exp_instr(exp_pc));
      check_eq("instr_is32", 32'(instr_is32), 32'(opens_32(hw_at(exp_pc))));
    end
    if (instr_valid && rdy_i) begin
      exp_pc = exp_pc + (opens_32(hw_at(exp_pc)) ? 32'd4 : 32'd2);
      delivered++;
      idle = 0;
    end else if (rdy_i && !br) begin
      idle++;
    end
    if (br) idle = 0;
    if (idle >= 60) begin
      check_eq("stall", 32'(idle), 32'd0);
      idle = 0;
    end
    if (last_acc) check_eq("req_addr", imem_addr, exp_req_addr);
    if (imem_rvalid && pend) pend = 1'b0;
    else if (pend) pend_wait--;
    if (last_acc) begin
      pend         = 1'b1;
      pend_addr    = imem_addr;
      pend_wait    = $urandom_range(lat_min, lat_max);
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (br) begin
      exp_pc       = tgt & ~32'h1;
      exp_req_addr = tgt & ~32'h3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   32'(imem_req), 32'd0);
    check_eq({tag, "_addr"},  imem_addr, 32'h0);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_instr"}, instr, 32'h0);
    check_eq({tag, "_is32"},  32'(instr_is32), 32'd0);
    check_eq({tag, "_pc"},    instr_pc, 32'h0);
  endtask

  initial begin
    logic        saw;
    logic        found;
    logic        got_acc;
    logic        req_seen;
    logic [31:0] addr0;
    logic [15:0] h;

    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 2; k++) begin
        h = 16'($urandom);
        if ($urandom_range(0, 3) == 0) h[15:11] = 5'd29 + 5'($urandom_range(0, 2));
        if (k == 0) mem[i][15:0] = h;
        else        mem[i][31:16] = h;
      end
    end
    mem[0] = 32'h4802_2001;
    mem[1] = 32'hF800_F000;
    for (int i = 2; i < 8; i++) mem[i] = {16'h2100 + 16'(2 * i + 1), 16'h2100 + 16'(2 * i)};
    mem[64] = 32'h2345_BEEF;

    pend = 1'b0; pend_wait = 0; pend_addr = 32'h0;
    exp_pc = 32'h0; exp_req_addr = 32'h0;
    lat_min = 0; lat_max = 0; spur_en = 1'b0; force_stale = 1'b0;
    idle = 0; delivered = 0;
    rst = 1'b0; branch = 1'b0; branch_target = 32'h0; instr_ready = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // Reset state, then release away from the clock edge.
    #2;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Basic fetch: two 16-bit instructions, then a BL pair.
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("c0_req", 32'(last_req), 32'd1);
    check_eq("c0_addr", last_addr, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("c1_valid", 32'(last_valid), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("c2_valid", 32'(last_valid), 32'd1);
    check_eq("c2_instr", last_instr, 32'h0000_2001);
    check_eq("c2_pc", last_pc, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("c3_instr", last_instr, 32'h0000_4802);
    check_eq("c3_pc", last_pc, 32'h2);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("c4_is32", 32'(last_is32), 32'd1);
    check_eq("c4_instr", last_instr, 32'hF000_F800);
    check_eq("c4_pc", last_pc, 32'h4);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("c5_valid", 32'(last_valid), 32'd1);
    check_eq("c5_pc", last_pc, 32'h8);

    // Back-pressure: FIFO fills, requests stop, then ready pulses reopen them.
    repeat (12) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("full_req", 32'(last_req), 32'd0);
    check_eq("full_valid", 32'(last_valid), 32'd1);
    saw = 1'b0;
    for (int p = 0; p < 3; p++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (last_req) saw = 1'b1;
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (last_req) saw = 1'b1;
    end
    check_eq("pulse_reenable", 32'(saw), 32'd1);

    // Branch to 0x102 while a slow read is still in flight.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      if (pend && pend_wait > 0) found = 1'b1;
      else cycle(1'b0, 32'h0, 1'b1, 1'b1);
    end
    check_eq("br_outst_setup", 32'(found), 32'd1);
    cycle(1'b1, 32'h0000_0102, 1'b1, 1'b1);
    got_acc = 1'b0;
    found   = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (last_acc && !got_acc) begin
        got_acc = 1'b1;
        check_eq("br_first_addr", last_addr, 32'h100);
      end
      if (last_valid) found = 1'b1;
    end
    check_eq("br_first_seen", 32'(found), 32'd1);
    check_eq("br_first_pc", last_pc, 32'h102);
    check_eq("br_first_instr", last_instr, 32'h0000_2345);

    // Branch coinciding with a read response and a would-be pop.
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (last_valid && pend && pend_wait == 0) found = 1'b1;
      else cycle(1'b0, 32'h0, !pend, 1'b1);
    end
    check_eq("br_rsp_setup", 32'(found), 32'd1);
    cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (last_valid) found = 1'b1;
    end
    check_eq("br_rsp_pc", last_pc, 32'h200);

    // Randomized traffic against the reference stream.
    lat_min = 0; lat_max = 3; spur_en = 1'b1; delivered = 0;
    for (int t = 0; t < 3000; t++) begin
      cycle($urandom_range(0, 19) == 0, 32'($urandom_range(0, 1023)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    check_eq("progress", 32'(delivered >= 300), 32'd1);

    // Memory stalled: request and address hold, the FIFO drains.
    lat_min = 0; lat_max = 0; spur_en = 1'b0;
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    req_seen = 1'b0;
    addr0    = imem_addr;
    for (int t = 0; t < 5; t++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check_eq("stall_addr", last_addr, addr0);
      if (req_seen) check_eq("stall_req", 32'(last_req), 32'd1);
      if (last_req) req_seen = 1'b1;
    end
    check_eq("stall_drained", 32'(last_valid), 32'd0);

    // Reset mid-transaction, with a stale response right after release.
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (last_acc) found = 1'b1;
    end
    rst = 1'b0;
    imem_rvalid = 1'b0;
    branch = 1'b0;
    #1;
    check_reset_outputs("rst1");
    pend = 1'b0; exp_pc = 32'h0; exp_req_addr = 32'h0; idle = 0;
    @(negedge clk);
    rst = 1'b1;
    force_stale = 1'b1;
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("rr_req", 32'(last_req), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("rr_instr", last_instr, 32'h0000_2001);
    check_eq("rr_pc", last_pc, 32'h0);
    repeat (20) cycle(1'b0, 32'h0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
